// File: rtl/hazard_forward_ctrl.sv
// Hazard unit for the 5-stage pipeline: EX/MEM and MEM/WB forwarding selects, load-use stall,
// multi-cycle multiplier interlock and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_wr,
    input  logic              ex_mem_read,
    input  logic              ex_mul,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_wr,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              hold_front,
    output logic              hold_ex,
    output logic              bubble_idex,
    output logic              mul_done,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int CW = $clog2(MUL_LAT) + 1;
    // First multiply cycle is spent in IDLE, last one at cnt==0, hence the -2.
    localparam logic [CW-1:0] CNT_INIT = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use;

    always_comb begin
        fwd_a = 2'b00;
        if (mem_reg_wr && (mem_rd == ex_rs) && (mem_rd != '0))
            fwd_a = 2'b10;
        else if (wb_reg_wr && (wb_rd == ex_rs) && (wb_rd != '0))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (mem_reg_wr && (mem_rd == ex_rt) && (mem_rd != '0))
            fwd_b = 2'b10;
        else if (wb_reg_wr && (wb_rd == ex_rt) && (wb_rd != '0))
            fwd_b = 2'b01;
    end

    assign load_use = ex_mem_read && ex_reg_wr && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_rt_used && (ex_rd == id_rt)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ex_mul && (MUL_LAT > 1)) begin
                    state_nxt = MUL_RUN;
                    cnt_nxt   = CNT_INIT;
                end
            end
            MUL_RUN: begin
                if (cnt != '0)
                    cnt_nxt = cnt - CW'(1);
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Multiply takes priority over load-use; EX is frozen while it runs.
    always_comb begin
        hold_front  = 1'b0;
        hold_ex     = 1'b0;
        bubble_idex = 1'b0;
        mul_done    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mul) begin
                    if (MUL_LAT == 1) begin
                        mul_done = 1'b1;
                    end else begin
                        hold_front = 1'b1;
                        hold_ex    = 1'b1;
                    end
                end else if (load_use) begin
                    hold_front  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end
            MUL_RUN: begin
                if (cnt != '0) begin
                    hold_front = 1'b1;
                    hold_ex    = 1'b1;
                end else begin
                    mul_done = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (hold_front && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule
